// File: rtl/pipe_reg_chain_if.sv
// Bundle of advance/flush controls, input word and pipeline outputs for pipe_reg_chain.
// The master drives the controls and input word; the slave is the pipeline itself.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCCW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic [OCCW-1:0]  occupancy;

  modport master (
    output en, flush, in_valid, d,
    input  q, out_valid, occupancy
  );

  modport slave (
    input  en, flush, in_valid, d,
    output q, out_valid, occupancy
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Stallable DEPTH-stage delay line with valid bits, synchronous flush and a running
// occupancy count; every output comes straight from a register.
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  pipe_reg_chain_if.slave bus
);
  localparam int OCCW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [OCCW-1:0]  occ_q;
  logic [OCCW-1:0]  occ_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (bus.flush) begin
      data_d = '{default: '0};
      vld_d  = '0;
      occ_d  = '0;
    end else if (bus.en) begin
      vld_d[0]  = bus.in_valid;
      data_d[0] = bus.in_valid ? bus.d : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        data_d[k] = data_q[k-1];
      end
      // Stays in 0..DEPTH because occ_q always equals the popcount of vld_q.
      occ_d = occ_q + OCCW'(bus.in_valid) - OCCW'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '{default: '0};
      vld_q  <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      occ_q  <= occ_d;
    end
  end

  assign bus.q         = data_q[DEPTH-1];
  assign bus.out_valid = vld_q[DEPTH-1];
  assign bus.occupancy = occ_q;

`ifndef SYNTHESIS
  int unsigned vld_pop;

  always_comb begin
    vld_pop = 0;
    for (int k = 0; k < DEPTH; k++) begin
      vld_pop += 32'(vld_q[k]);
    end
  end

  a_occ_matches_valids: assert property (@(posedge clk) disable iff (reset)
    32'(occ_q) == vld_pop);
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Drives three pipe_reg_chain configurations (1x1, 8x4, 32x7) from one stimulus stream
// and compares them every cycle against a history-queue model.
module tb_pipe_reg_chain;
  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [31:0] d;
  logic        chk_en;

  int n_chk;
  int n_err;

  typedef struct {
    bit        v;
    bit [31:0] d;
  } ent_t;

  ent_t hist[$];
  ent_t ent;

  pipe_reg_chain_if #(.WIDTH(1),  .DEPTH(1)) if1 ();
  pipe_reg_chain_if #(.WIDTH(8),  .DEPTH(4)) if4 ();
  pipe_reg_chain_if #(.WIDTH(32), .DEPTH(7)) if7 ();

  assign if1.en = en;  assign if1.flush = flush;  assign if1.in_valid = in_valid;  assign if1.d = d[0:0];
  assign if4.en = en;  assign if4.flush = flush;  assign if4.in_valid = in_valid;  assign if4.d = d[7:0];
  assign if7.en = en;  assign if7.flush = flush;  assign if7.in_valid = in_valid;  assign if7.d = d;

  pipe_reg_chain #(.WIDTH(1),  .DEPTH(1)) u_d1 (.clk(clk), .reset(reset), .bus(if1));
  pipe_reg_chain #(.WIDTH(8),  .DEPTH(4)) u_d4 (.clk(clk), .reset(reset), .bus(if4));
  pipe_reg_chain #(.WIDTH(32), .DEPTH(7)) u_d7 (.clk(clk), .reset(reset), .bus(if7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: newest accepted word at the front; the word emerging from a depth-D pipe
  // is the one accepted D advances ago, and missing history means an empty stage.
  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      hist.delete();
    end else if (en) begin
      ent.v = in_valid;
      ent.d = in_valid ? d : 32'h0;
      hist.push_front(ent);
      if (hist.size() > 7) void'(hist.pop_back());
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(string nm, int dep, logic [31:0] mask,
                            logic ov, logic [31:0] qv, logic [31:0] occ);
    logic        e_v;
    logic [31:0] e_d;
    int          e_occ;
    e_v   = 1'b0;
    e_d   = 32'h0;
    e_occ = 0;
    for (int i = 0; i < dep && i < hist.size(); i++) begin
      if (hist[i].v) e_occ++;
    end
    if (hist.size() >= dep) begin
      e_v = hist[dep-1].v;
      e_d = hist[dep-1].d & mask;
    end
    chk({nm, ".out_valid"}, 32'(ov), 32'(e_v));
    chk({nm, ".q"}, qv, e_d);
    chk({nm, ".occupancy"}, occ, 32'(e_occ));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst("d1", 1, 32'h1,        if1.out_valid, 32'(if1.q), 32'(if1.occupancy));
      check_inst("d4", 4, 32'hFF,       if4.out_valid, 32'(if4.q), 32'(if4.occupancy));
      check_inst("d7", 7, 32'hFFFFFFFF, if7.out_valid, if7.q,      32'(if7.occupancy));
    end
  end

  task automatic cyc(bit e, bit f, bit v, logic [31:0] dv);
    en       = e;
    flush    = f;
    in_valid = v;
    d        = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " d1.out_valid"}, 32'(if1.out_valid), 32'h0);
    chk({tag, " d4.q"},         32'(if4.q),         32'h0);
    chk({tag, " d4.out_valid"}, 32'(if4.out_valid), 32'h0);
    chk({tag, " d4.occupancy"}, 32'(if4.occupancy), 32'h0);
    chk({tag, " d7.occupancy"}, 32'(if7.occupancy), 32'h0);
  endtask

  logic [31:0] s1 [5];

  initial begin
    n_chk    = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    reset    = 1'b0;
    en       = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    d        = 32'h0;
    s1       = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

    #2 reset = 1'b1;
    #1 chk_zero("reset");
    cyc(1, 0, 1, 32'hDEAD_BEEF);
    chk_zero("reset held");
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Latency and throughput
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, i < 5, i < 5 ? s1[i] : 32'h0);
      if (i == 0) chk("lat d1.q", 32'(if1.q), 32'h1);
      if (i == 2) chk("lat d4 early out_valid", 32'(if4.out_valid), 32'h0);
      if (i == 3) begin
        chk("lat d4.q", 32'(if4.q), 32'h11);
        chk("lat d4.occupancy", 32'(if4.occupancy), 32'h4);
      end
      if (i == 4) chk("lat d4.q second", 32'(if4.q), 32'h22);
      if (i == 6) chk("lat d7.q", if7.q, 32'h11);
      if (i == 7) begin
        chk("drain d4.q", 32'(if4.q), 32'h55);
        chk("drain d4.occupancy", 32'(if4.occupancy), 32'h1);
      end
    end

    // Stall
    cyc(0, 1, 0, 32'h0);
    cyc(1, 0, 1, 32'hA5);
    cyc(1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 32'h5A);
      chk("stall d4.occupancy", 32'(if4.occupancy), 32'h1);
    end
    cyc(1, 0, 0, 32'h0);
    chk("stall d4 early out_valid", 32'(if4.out_valid), 32'h0);
    cyc(1, 0, 0, 32'h0);
    chk("stall d4.q", 32'(if4.q), 32'hA5);
    chk("stall d4.out_valid", 32'(if4.out_valid), 32'h1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 32'h0);

    // Bubbles carry zero data
    cyc(0, 1, 0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, (i % 2) == 0, 32'hFF);
      if (i == 1) chk("bubble d1.q", 32'(if1.q), 32'h0);
      if (i == 3) begin
        chk("bubble d4.q valid", 32'(if4.q), 32'hFF);
        chk("bubble d4.occupancy", 32'(if4.occupancy), 32'h2);
      end
      if (i == 4) begin
        chk("bubble d4.q hole", 32'(if4.q), 32'h0);
        chk("bubble d4.out_valid hole", 32'(if4.out_valid), 32'h0);
      end
    end

    // Flush wins over en
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 32'h10 + 32'(i));
    chk("prefill d4.occupancy", 32'(if4.occupancy), 32'h4);
    cyc(1, 1, 1, 32'h77);
    chk_zero("flush");
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 32'h0);

    // Async reset mid-stream
    cyc(0, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 32'hC0 + 32'(i));
    cyc(1, 0, 0, 32'h0);
    chk("pre-reset d4.occupancy", 32'(if4.occupancy), 32'h3);
    chk("pre-reset d4.q", 32'(if4.q), 32'hC1);
    #1 reset = 1'b1;
    #1 chk_zero("async reset");
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, i < 5, i < 5 ? s1[i] + 32'h20 : 32'h0);
      if (i == 3) chk("post-reset d4.q", 32'(if4.q), 32'h31);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised, stallable register pipeline: a chain of DEPTH stages, each WIDTH data bits wide plus a valid bit. It generalises the single flip-flop register into a multi-stage delay line with a shared advance enable, a synchronous flush, and a live occupancy count. It is used wherever a datapath needs a fixed, stall-aware delay, for example aligning operands with a multi-cycle unit.

## Interface
- WIDTH, 8, data bits per stage; legal range is 1 or more.
- DEPTH, 4, number of stages, which is also the latency in advance cycles; legal range is 1 or more.
- OCCW, $clog2(DEPTH+1), width of the occupancy output; derived, not overridden.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- en  input  1  advance; when 1 at an edge, every stage moves one position.
- flush  input  1  synchronous clear of all stages; takes priority over en.
- in_valid  input  1  qualifies d; sampled only when en=1.
- d  input  WIDTH  data into stage 0.
- q  output  WIDTH  data of stage DEPTH-1, taken directly from a register.
- out_valid  output  1  valid bit of stage DEPTH-1.
- occupancy  output  OCCW  number of stages whose valid bit is 1, in the range 0..DEPTH.

## Operation
- State: data[0..DEPTH-1] (each WIDTH bits), vld[0..DEPTH-1], and an occupancy register.
- Reset (reset=1, asynchronous assert): all data = 0, all vld = 0, occupancy = 0. Therefore q=0, out_valid=0, occupancy=0 while reset is held and after it deasserts.
- Priority at each rising edge, highest first: reset, then flush, then en, then hold.
- Flush=1: all data cleared to 0, all vld cleared to 0, occupancy cleared to 0. The input at that edge is discarded even if en=1 and in_valid=1.
- Advance (en=1, flush=0):
  - vld[0] <= in_valid.
  - data[0] <= d when in_valid=1, otherwise 0. Bubbles always carry zero data.
  - For k = 1..DEPTH-1: vld[k] <= vld[k-1] and data[k] <= data[k-1].
  - The contents of stage DEPTH-1 are dropped. There is no backpressure; the consumer must take q while out_valid=1 and en=1.
- Hold (en=0, flush=0): all registers keep their values. in_valid and d are ignored.
- Occupancy is maintained incrementally, not by a popcount:
  - On advance: occ_next = occ + in_valid - vld[DEPTH-1], using current values.
  - Bounds: the result cannot exceed DEPTH or go below 0. The implementation must keep this invariant without saturation logic.
  - Invariant at all times: occupancy equals the popcount of vld. The bench checks this every cycle.
- DEPTH=1: the block degenerates to a single enabled register with valid. Occupancy is 1 bit and equals out_valid.
- No combinational path from any input to any output.

## Timing
- Latency: a word accepted at edge N with en=1 appears on q/out_valid after DEPTH edges with en=1, counting edge N. Stall cycles (en=0) add one cycle each.
- Throughput: one word per clock while en=1.
- Outputs change only at clk rising edges, or immediately on reset assertion.
- Reset deassertion: the first edge that can load data is the first rising edge with reset=0.
- Reset mid-stream: all in-flight words are lost and no partial state survives.
- Flush and en both 1 on the same edge: the flush wins, and the pipe is empty after that edge.

## Test plan
- Reset and latency: assert reset, release, then hold en=1 and feed d=0x11,0x22,0x33,0x44,0x55 with in_valid=1 (DEPTH=4). Expect q=0x11 with out_valid=1 exactly 4 edges after the first load, then 0x22..0x55 on consecutive cycles; occupancy climbs to 4.
- Stall: load 0xA5 into a DEPTH=4 pipe, drop en for 3 cycles after the second edge, then raise it. Expect q=0xA5 to appear 7 cycles after the load, with occupancy holding at 1 during the stall.
- Bubbles: feed in_valid pattern 1,0,1,0 with d=0xFF throughout. Expect out_valid pattern 1,0,1,0; q=0xFF on valid cycles and q=0x00 on bubble cycles; occupancy steady at 2 once the pipe is full.
- Flush with en: fill to occupancy=4, then apply flush=1, en=1, in_valid=1, d=0x77. Expect occupancy=0, out_valid=0, q=0 next cycle, and 0x77 never emerges.
- Asynchronous reset mid-stream: with occupancy=3, pulse reset between clock edges. Expect all outputs to go to 0 before the next edge; subsequent data flows normally.
- Configurations: repeat the first scenario at WIDTH=1, DEPTH=1 and at WIDTH=32, DEPTH=7. Expect latency equal to DEPTH and the occupancy equals popcount(vld) check to hold on every cycle.
